// File: rtl/core_pkg.sv
// Shared EX-stage definitions: M-extension funct3 codes and the mul/div FSM state encoding.
package core_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CALC   = 2'b01,
        ST_FINISH = 2'b10,
        ST_DONE   = 2'b11
    } md_state_t;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negation: operand magnitude on the way in, sign fix-up on the way out.
module muldiv_sign_fix #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    always_comb begin
        res = neg ? (~val + 1'b1) : val;
    end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide for the EX stage: radix-2 shift-add multiply and restoring divide.
module ex_muldiv_unit
    import core_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter bit          FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;

    md_state_t         state, state_nxt;
    logic [2:0]        f3_q;
    logic [XLEN-1:0]   a_raw_q, mcand_q, result_q;
    logic [2*XLEN-1:0] prod_q;
    logic [XLEN:0]     rem_q;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, div0_q, ovf_q;

    logic              is_div_in, a_signed, b_signed, sign_a, sign_b;
    logic              div0_in, ovf_in, accept;
    logic [XLEN-1:0]   abs_a, abs_b, mul_addend, final_res;
    logic [XLEN:0]     mul_sum;
    logic [XLEN+1:0]   div_trial;
    logic [2*XLEN-1:0] fix_in, fixed;

    always_comb begin
        is_div_in = funct3[2];
        a_signed  = is_div_in ? ~funct3[0] : (funct3 != F3_MULHU);
        b_signed  = is_div_in ? ~funct3[0] : (funct3 == F3_MUL || funct3 == F3_MULH);
        sign_a    = a_signed & op_a[XLEN-1];
        sign_b    = b_signed & op_b[XLEN-1];
        div0_in   = is_div_in & (op_b == '0);
        ovf_in    = is_div_in & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
        accept    = (state == ST_IDLE) & start & ~kill;
    end

    muldiv_sign_fix #(.W(XLEN)) u_abs_a (.val(op_a), .neg(sign_a), .res(abs_a));
    muldiv_sign_fix #(.W(XLEN)) u_abs_b (.val(op_b), .neg(sign_b), .res(abs_b));

    // Divide reuses the low half of prod_q as dividend shifting out / quotient shifting in.
    always_comb begin
        mul_addend = prod_q[0] ? mcand_q : '0;
        mul_sum    = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mul_addend};
        div_trial  = {rem_q, prod_q[XLEN-1]} - {2'b00, mcand_q};
    end

    always_comb begin
        if (f3_q[2])
            fix_in = {{XLEN{1'b0}}, (f3_q[1] ? rem_q[XLEN-1:0] : prod_q[XLEN-1:0])};
        else
            fix_in = prod_q;
    end

    muldiv_sign_fix #(.W(2*XLEN)) u_fix (.val(fix_in), .neg(neg_q), .res(fixed));

    // Special-case results are forced here so they stay exact even when they ran the full CALC.
    always_comb begin
        if (div0_q)
            final_res = f3_q[1] ? a_raw_q : '1;
        else if (ovf_q)
            final_res = f3_q[1] ? '0 : a_raw_q;
        else if (f3_q[2] || f3_q == F3_MUL)
            final_res = fixed[XLEN-1:0];
        else
            final_res = fixed[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = (FAST_SPECIAL && (div0_in || ovf_in)) ? ST_FINISH : ST_CALC;
            ST_CALC:   if (kill) state_nxt = ST_IDLE;
                       else if (cnt_q == CW'(XLEN - 1)) state_nxt = ST_FINISH;
            ST_FINISH: state_nxt = kill ? ST_IDLE : ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            f3_q     <= '0;
            a_raw_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
        end else if (accept) begin
            f3_q    <= funct3;
            a_raw_q <= op_a;
            mcand_q <= abs_b;
            prod_q  <= {{XLEN{1'b0}}, abs_a};
            rem_q   <= '0;
            cnt_q   <= '0;
            neg_q   <= (is_div_in && funct3[1]) ? sign_a : (sign_a ^ sign_b);
            div0_q  <= div0_in;
            ovf_q   <= ovf_in;
        end else if (state == ST_CALC && !kill) begin
            cnt_q <= cnt_q + 1'b1;
            if (f3_q[2]) begin
                prod_q[XLEN-1:0] <= {prod_q[XLEN-2:0], ~div_trial[XLEN+1]};
                rem_q <= div_trial[XLEN+1] ? {rem_q[XLEN-1:0], prod_q[XLEN-1]} : div_trial[XLEN:0];
            end else begin
                prod_q <= {mul_sum, prod_q[XLEN-1:1]};
            end
        end else if (state == ST_FINISH && !kill) begin
            result_q <= final_res;
        end
    end

    always_comb begin
        busy   = (state != ST_IDLE);
        done   = (state == ST_DONE);
        result = result_q;
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Scoreboard bench for ex_muldiv_unit: directed RV32M corner cases plus randomized operations.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy, done;
    logic [31:0] result;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [31:0] res;
        int unsigned acc;
        int unsigned lat;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t sb_q[$];

    ex_muldiv_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa64, sb64, ua64, ub64, p;
        logic signed [31:0] as32, bs32;
        sa64 = {{32{a[31]}}, a};
        sb64 = {{32{b[31]}}, b};
        ua64 = {32'd0, a};
        ub64 = {32'd0, b};
        as32 = a;
        bs32 = b;
        case (f)
            3'b000: begin p = sa64 * sb64; return p[31:0]; end
            3'b001: begin p = sa64 * sb64; return p[63:32]; end
            3'b010: begin p = sa64 * ub64; return p[63:32]; end
            3'b011: begin p = ua64 * ub64; return p[63:32]; end
            3'b100: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return as32 / bs32;
            end
            3'b101: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return as32 % bs32;
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            if (sb_q.size() != 0 && !done) begin
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL busy_hold busy=%0b required=1 at cycle %0d", busy, cyc);
                end
            end
            if (done) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_done result=%h required no done", result);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    checks++;
                    if (result !== e.res) begin
                        errors++;
                        $display("FAIL result f3=%0d a=%h b=%h got=%h required=%h", e.f, e.a, e.b, result, e.res);
                    end
                    checks++;
                    if (cyc - e.acc != e.lat) begin
                        errors++;
                        $display("FAIL latency f3=%0d got=%0d required=%0d", e.f, cyc - e.acc, e.lat);
                    end
                    checks++;
                    if (!busy) begin
                        errors++;
                        $display("FAIL busy_at_done busy=%0b required=1", busy);
                    end
                end
            end
        end
    end

    task automatic send(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
        exp_t e;
        @(negedge clk);
        start = 1'b1; funct3 = f; op_a = a; op_b = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom;
        if (track) begin
            e.res = ref_model(f, a, b);
            e.acc = cyc;
            e.lat = is_special(f, a, b) ? 1 : 33;
            e.f = f; e.a = a; e.b = b;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        while ((sb_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (sb_q.size() != 0 || busy) begin
            errors++;
            $display("FAIL timeout pending=%0d busy=%0b required pending=0 busy=0", sb_q.size(), busy);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        send(f, a, b, 1'b1);
        wait_idle();
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, req);
        end
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'd7};
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        repeat (3) @(negedge clk);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_result", result, 32'd0);
        rst_n = 1'b1;

        run(3'b000, 32'd7, 32'hFFFF_FFFD);
        run(3'b001, 32'h8000_0000, 32'h8000_0000);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'b100, 32'hFFFF_FFF9, 32'd2);
        run(3'b110, 32'hFFFF_FFF9, 32'd2);
        run(3'b101, 32'd5, 32'd0);
        run(3'b111, 32'd5, 32'd0);
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'b100, 32'hFFFF_FFFB, 32'd0);
        run(3'b110, 32'hFFFF_FFFB, 32'd0);
        run(3'b111, 32'd100, 32'd7);
        run(3'b101, 32'd100, 32'd7);

        // Kill mid-divide: no done, result keeps the previous 14.
        send(3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        @(negedge clk);
        check_val("kill_busy", {31'd0, busy}, 32'd0);
        check_val("kill_result", result, 32'd14);
        repeat (40) @(negedge clk);
        check_val("kill_result_later", result, 32'd14);

        // A start while busy must be ignored; latency check catches a restart.
        send(3'b000, 32'd7, 32'hFFFF_FFFD, 1'b1);
        repeat (4) @(negedge clk);
        start = 1'b1; funct3 = 3'b101; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle();

        // Reset in the middle of a multiply discards it.
        send(3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_val("midrst_busy", {31'd0, busy}, 32'd0);
        check_val("midrst_done", {31'd0, done}, 32'd0);
        check_val("midrst_result", result, 32'd0);
        repeat (40) @(negedge clk);
        run(3'b011, 32'hDEAD_BEEF, 32'h0BAD_F00D);

        for (int i = 0; i < 60; i++) begin
            run(3'($urandom_range(0, 7)), pick(), pick());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cycles=%0d required completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
